// File: rtl/axi_burst_write_engine.sv
// -----------------------------------------------------------------------------
// axi_burst_write_engine
//
// Turns a (start address, beat count) request into one or more AXI4 INCR
// write bursts. The write data comes from a simple valid/ready stream.
//
// Each burst is the smallest of three limits:
//   - the beats still remaining in the request,
//   - MAX_BURST,
//   - the beats left before the next 4 KB address boundary.
// Only one burst is in flight at a time: AW, then all W beats, then B.
//
// Ports
//   axi_aclk, axi_resetn    clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake; req_ready is high only when idle
//   req_addr, req_beats     start byte address (beat aligned), total beats
//   done                    one-cycle pulse when the whole request finishes
//   err                     sticky: some burst returned a non-OKAY bresp
//   s_data/s_valid/s_ready  write data stream, passed straight to the W channel
//   axi_aw*                 AXI write address channel (master side)
//   axi_w*                  AXI write data channel (master side)
//   axi_b*                  AXI write response channel (master side)
// -----------------------------------------------------------------------------
module axi_burst_write_engine #(
   parameter int IDSIZE    = 3,
   parameter int ID        = 0,
   parameter int ASIZE     = 32,
   parameter int DSIZE     = 256,
   parameter int LSIZE     = 8,
   parameter int MAX_BURST = 256,
   parameter int TSIZE     = 24
) (
   input  logic                 axi_aclk,
   input  logic                 axi_resetn,
   // request / status
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ASIZE-1:0]     req_addr,
   input  logic [TSIZE-1:0]     req_beats,
   output logic                 done,
   output logic                 err,
   // write data stream
   input  logic [DSIZE-1:0]     s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   // AW channel
   output logic [IDSIZE-1:0]    axi_awid,
   output logic [ASIZE-1:0]     axi_awaddr,
   output logic [LSIZE-1:0]     axi_awlen,
   output logic [2:0]           axi_awsize,
   output logic [1:0]           axi_awburst,
   output logic                 axi_awvalid,
   input  logic                 axi_awready,
   // W channel
   output logic [DSIZE-1:0]     axi_wdata,
   output logic [DSIZE/8-1:0]   axi_wstrb,
   output logic                 axi_wlast,
   output logic                 axi_wvalid,
   input  logic                 axi_wready,
   // B channel
   input  logic [IDSIZE-1:0]    axi_bid,
   input  logic [1:0]           axi_bresp,
   input  logic                 axi_bvalid,
   output logic                 axi_bready
);

   localparam int BYTES  = DSIZE / 8;
   localparam int BSHIFT = $clog2(BYTES);
   // Burst length needs one bit more than awlen: MAX_BURST may equal 2**LSIZE.
   localparam int BW     = LSIZE + 1;
   // Working width for the min() compare: holds the remaining count and the
   // 4 KB room (up to 4096 beats at byte-wide data).
   localparam int CW     = (TSIZE > 13) ? TSIZE + 1 : 14;

   localparam logic [IDSIZE-1:0] ID_C     = IDSIZE'(ID);
   localparam logic [2:0]        AWSIZE_C = 3'(BSHIFT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_AW,
      S_W,
      S_B,
      S_DONE
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [ASIZE-1:0]  addr_q;
   logic [TSIZE-1:0]  remain_q;
   logic [BW-1:0]     blen_q;
   logic [BW-1:0]     beat_q;
   logic              err_q;

   logic              accept;
   logic              beat_hs;
   logic              last_beat;
   logic              b_hit;
   logic [TSIZE-1:0]  remain_after;

   // Length of the next burst from the current address and remaining count.
   // The address is beat aligned, so the room to the 4 KB boundary divides
   // exactly into beats.
   function automatic logic [BW-1:0] calc_blen(input logic [ASIZE-1:0] a,
                                               input logic [TSIZE-1:0] rem);
      logic [12:0]   room_bytes;
      logic [CW-1:0] room;
      logic [CW-1:0] n;
      room_bytes = 13'h1000 - {1'b0, a[11:0]};
      room       = CW'(room_bytes >> BSHIFT);
      n          = CW'(rem);
      if (n > CW'(MAX_BURST)) n = CW'(MAX_BURST);
      if (n > room)           n = room;
      return BW'(n);
   endfunction

   assign accept       = req_ready && req_valid && (req_beats != '0);
   assign beat_hs      = (state_q == S_W) && s_valid && axi_wready;
   assign last_beat    = (beat_q == blen_q - BW'(1));
   assign b_hit        = (state_q == S_B) && axi_bvalid && (axi_bid == ID_C);
   assign remain_after = remain_q - TSIZE'(blen_q);

   // State register
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs
   always_comb begin
      state_d     = state_q;
      req_ready   = 1'b0;
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      axi_wlast   = 1'b0;
      s_ready     = 1'b0;
      axi_bready  = 1'b0;
      done        = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Gated by the reset pin so req_ready is low while reset is held.
            req_ready = axi_resetn;
            if (accept) state_d = S_CALC;
         end
         S_CALC: begin
            state_d = S_AW;
         end
         S_AW: begin
            axi_awvalid = 1'b1;
            if (axi_awready) state_d = S_W;
         end
         S_W: begin
            axi_wvalid = s_valid;
            s_ready    = axi_wready;
            axi_wlast  = s_valid && last_beat;
            if (beat_hs && last_beat) state_d = S_B;
         end
         S_B: begin
            axi_bready = 1'b1;
            if (b_hit) state_d = (remain_after == '0) ? S_DONE : S_CALC;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Address, counters and sticky error
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         addr_q   <= '0;
         remain_q <= '0;
         blen_q   <= '0;
         beat_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  addr_q   <= req_addr;
                  remain_q <= req_beats;
                  err_q    <= 1'b0;
               end
            end
            S_CALC: begin
               blen_q <= calc_blen(addr_q, remain_q);
               beat_q <= '0;
            end
            S_W: begin
               if (beat_hs) beat_q <= beat_q + BW'(1);
            end
            S_B: begin
               if (b_hit) begin
                  // Carry past ASIZE falls off: the address wraps.
                  addr_q   <= addr_q + (ASIZE'(blen_q) << BSHIFT);
                  remain_q <= remain_after;
                  if (axi_bresp != 2'b00) err_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign axi_awid    = ID_C;
   assign axi_awaddr  = addr_q;
   assign axi_awlen   = LSIZE'(blen_q - BW'(1));
   assign axi_awsize  = AWSIZE_C;
   assign axi_awburst = 2'b01;
   assign axi_wdata   = s_data;
   assign axi_wstrb   = '1;
   assign err         = err_q;

endmodule
